loadstore_unit: RTL

LOADSTORE_UNIT -- requirements
Module: loadstore_unit

---
 rtl/loadstore_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/loadstore_unit.sv
// loadstore_unit: MIPS-style byte/half/word loads and stores over a word-addressed
// bus with wait states, little-endian lanes and misalignment detection.
module loadstore_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] base,
    input  logic [15:0] offset,
    input  logic [31:0] rt_data,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        write_enable_ld,
    output logic [31:0] write_data_ld,
    output logic [3:0]  byteenable_ld,
    output logic        busy,
    output logic        done,
    output logic        addr_error
);
    typedef enum logic [1:0] {IDLE, ACCESS, WB, FIN} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_eff, r_rt, r_rdata;
    logic [3:0]  r_op;
    logic        r_err;
    logic [31:0] w_eff;
    logic        w_is_ld, w_is_st, w_mis, w_r_ld, w_r_st;
    logic [1:0]  w_k;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_eff   = base + {{16{offset[15]}}, offset};
    assign w_is_ld = op <= 4'd6;
    assign w_is_st = op == 4'd8 || op == 4'd9 || op == 4'd11;
    assign w_mis   = ((op == 4'd1 || op == 4'd5 || op == 4'd9) && w_eff[0]) ||
                     ((op == 4'd3 || op == 4'd11) && w_eff[1:0] != 2'd0);
    assign w_r_ld  = r_op <= 4'd6;
    assign w_r_st  = r_op == 4'd8 || r_op == 4'd9 || r_op == 4'd11;
    assign w_k     = r_eff[1:0];
    assign w_byte  = w_k == 2'd0 ? r_rdata[7:0] : w_k == 2'd1 ? r_rdata[15:8] :
                     w_k == 2'd2 ? r_rdata[23:16] : r_rdata[31:24];
    assign w_half  = w_k[1] ? r_rdata[31:16] : r_rdata[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_eff   <= '0;
            r_op    <= '0;
            r_rt    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_eff <= w_eff;
                r_op  <= op;
                r_rt  <= rt_data;
                r_err <= w_mis;
            end
            if (r_state == ACCESS && !mem_waitrequest)
                r_rdata <= mem_readdata;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (w_mis || !(w_is_ld || w_is_st)) ? FIN : ACCESS;
            ACCESS:  if (!mem_waitrequest) w_next = w_r_ld ? WB : FIN;
            default: w_next = IDLE;
        endcase
    end

    // Bus side is only live in ACCESS so address/data read 0 whenever idle or reset.
    always_comb begin
        busy            = r_state != IDLE;
        done            = r_state == WB || r_state == FIN;
        addr_error      = r_state == FIN && r_err;
        write_enable_ld = r_state == WB;
        mem_read        = r_state == ACCESS && w_r_ld;
        mem_write       = r_state == ACCESS && w_r_st;
        mem_address     = r_state == ACCESS ? {r_eff[31:2], 2'b00} : 32'd0;
        mem_byteenable  = r_state != ACCESS ? 4'b0000 :
                          r_op == 4'd8 ? 4'b0001 << w_k :
                          r_op == 4'd9 ? (w_k[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        mem_writedata   = !mem_write ? 32'd0 :
                          r_op == 4'd8 ? {4{r_rt[7:0]}} :
                          r_op == 4'd9 ? {2{r_rt[15:0]}} : r_rt;
        byteenable_ld   = r_state != WB ? 4'b0000 :
                          r_op == 4'd2 ? 4'b1111 << ~w_k :
                          r_op == 4'd6 ? 4'b1111 >> w_k : 4'b1111;
        write_data_ld   = '0;
        if (r_state == WB) begin
            case (r_op)
                4'd0:    write_data_ld = {{24{w_byte[7]}}, w_byte};
                4'd4:    write_data_ld = {24'd0, w_byte};
                4'd1:    write_data_ld = {{16{w_half[15]}}, w_half};
                4'd5:    write_data_ld = {16'd0, w_half};
                4'd2:    write_data_ld = r_rdata << {~w_k, 3'b000};
                4'd6:    write_data_ld = r_rdata >> {w_k, 3'b000};
                default: write_data_ld = r_rdata;
            endcase
        end
    end
endmodule
